// File: rtl/image_rom_pkg.sv
// Shared defaults for the image ROM arbiter: address/pixel layout and owner-tag sizing.
// Round-robin arbitration is enabled by defining IMAGE_ROM_ARB_RR_EN.
package image_rom_pkg;

   localparam int ADDR_W_DEF   = 12;
   localparam int DATA_W_DEF   = 12;

   // ROM address is {y[5:0], x[5:0]}; pixel is {r[3:0], g[3:0], b[3:0]}
   localparam int ADDR_X_LSB   = 0;
   localparam int ADDR_Y_LSB   = 6;
   localparam int ADDR_FIELD_W = 6;
   localparam int PIX_B_LSB    = 0;
   localparam int PIX_G_LSB    = 4;
   localparam int PIX_R_LSB    = 8;
   localparam int PIX_FIELD_W  = 4;

   function automatic int owner_tag_w(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

endpackage

// File: rtl/image_rom_arbiter_rr_grant.sv
// One-hot grant picker: first requester found when searching upward from i_ptr (wrapping).
// Tying i_ptr to zero turns it into a fixed lowest-index-wins priority encoder.
module rr_grant
   import image_rom_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int TAG_W = owner_tag_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [TAG_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt
);

   always_comb begin
      logic w_found;
      w_found = 1'b0;
      o_gnt   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && i_req[i] && (((int'(i_ptr) + k) % N_REQ) == i)) begin
               o_gnt[i] = 1'b1;
               w_found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/image_rom_arbiter.sv
// Shares one 1-cycle-latency pixel ROM among N_REQ requesters with burst locking.
// Define IMAGE_ROM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module image_rom_arbiter
   import image_rom_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ-1:0]        i_req_lock,
   input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
   output logic [N_REQ-1:0]        o_gnt,
   output logic [ADDR_W-1:0]       o_rom_addr,
   input  logic [DATA_W-1:0]       i_rom_rgb,
   output logic [DATA_W-1:0]       o_rdata,
   output logic [N_REQ-1:0]        o_rvalid
);

   localparam int TAG_W = owner_tag_w(N_REQ);

   logic [N_REQ-1:0]  r_prev_gnt;
   logic [N_REQ-1:0]  w_arb_gnt;
   logic [N_REQ-1:0]  w_gnt;
   logic              w_keep;
   logic [TAG_W-1:0]  w_ptr;
   logic [TAG_W-1:0]  w_gnt_tag;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [TAG_W-1:0]  r_tag1;
   logic              r_vld1;

   assign w_keep = |(r_prev_gnt & i_req & i_req_lock);
   // The grant is combinational, so it must be forced quiet while reset is held
   assign w_gnt  = !i_rst_n ? '0 : (w_keep ? r_prev_gnt : w_arb_gnt);

   rr_grant #(
      .N_REQ (N_REQ),
      .TAG_W (TAG_W)
   ) u_grant (
      .i_req (i_req),
      .i_ptr (w_ptr),
      .o_gnt (w_arb_gnt)
   );

   always_comb begin
      w_gnt_tag  = '0;
      w_sel_addr = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_gnt[k]) begin
            w_gnt_tag  = TAG_W'(k);
            w_sel_addr = i_req_addr[k*ADDR_W +: ADDR_W];
         end
      end
   end

   assign o_gnt      = w_gnt;
   assign o_rom_addr = (|w_gnt) ? w_sel_addr : r_rom_addr;

`ifdef IMAGE_ROM_ARB_RR_EN
   logic [TAG_W-1:0] r_ptr;

   // Locked continuation grants leave the search start untouched
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
      end else if ((|w_gnt) && !w_keep) begin
         r_ptr <= (int'(w_gnt_tag) == N_REQ - 1) ? '0 : w_gnt_tag + TAG_W'(1);
      end
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev_gnt <= '0;
         r_rom_addr <= '0;
         r_tag1     <= '0;
         r_vld1     <= 1'b0;
         o_rvalid   <= '0;
         o_rdata    <= '0;
      end else begin
         r_prev_gnt <= w_gnt;
         r_rom_addr <= o_rom_addr;
         r_tag1     <= w_gnt_tag;
         r_vld1     <= |w_gnt;
         o_rvalid   <= r_vld1 ? (N_REQ'(1) << r_tag1) : '0;
         if (r_vld1) begin
            o_rdata <= i_rom_rgb;
         end
      end
   end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter with a registered-read ROM model.
// Expectations follow IMAGE_ROM_ARB_RR_EN when it is defined for the build.
module tb_image_rom_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  req_lock;
   logic [47:0] req_addr;
   logic [3:0]  gnt;
   logic [11:0] rom_addr;
   logic [11:0] rom_rgb = 12'h000;
   logic [11:0] rdata;
   logic [3:0]  rvalid;

   int checks = 0;
   int errors = 0;

   image_rom_arbiter #(
      .N_REQ  (4),
      .ADDR_W (12),
      .DATA_W (12)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_req_lock (req_lock),
      .i_req_addr (req_addr),
      .o_gnt      (gnt),
      .o_rom_addr (rom_addr),
      .i_rom_rgb  (rom_rgb),
      .o_rdata    (rdata),
      .o_rvalid   (rvalid)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_f(input logic [11:0] a);
      return a ^ 12'hA5C;
   endfunction

   always @(posedge clk) rom_rgb <= rom_f(rom_addr);

   function automatic int exp_idx(input int k);
`ifdef IMAGE_ROM_ARB_RR_EN
      return k % 4;
`else
      return (k < 0) ? 0 : 0;
`endif
   endfunction

   function automatic logic [3:0] exp_gnt(input int k);
      return 4'(32'd1 << exp_idx(k));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) begin
         $display("chk %-16s obs=%0h", tag, obs);
      end else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [11:0] a);
      req_addr[i*12 +: 12] = a;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      req      = '0;
      req_lock = '0;
      tick();
      rst_n    = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      req      = '0;
      req_lock = '0;
      req_addr = '0;
      repeat (2) tick();

      // reset holds every output low even with a request present
      req = 4'b0001;
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_rom_addr", 32'(rom_addr), 32'h0);
      tick();
      rst_n = 1'b1;

      // single read of 0x041
      set_addr(0, 12'h041);
      req = 4'b0001;
      @(negedge clk);
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_rom_addr", 32'(rom_addr), 32'h041);
      tick();
      req = '0;
      @(negedge clk);
      chk("t1_rvalid_early", 32'(rvalid), 32'h0);
      chk("t1_addr_hold", 32'(rom_addr), 32'h041);
      chk("t1_gnt_idle", 32'(gnt), 32'h0);
      tick();
      @(negedge clk);
      chk("t1_rvalid", 32'(rvalid), 32'h1);
      chk("t1_rdata", 32'(rdata), 32'hA1D);
      tick();
      @(negedge clk);
      chk("t1_rvalid_end", 32'(rvalid), 32'h0);
      chk("t1_rdata_hold", 32'(rdata), 32'hA1D);

      // all four requesting for 8 clk
      do_reset();
      for (int i = 0; i < 4; i++) set_addr(i, 12'(12'h200 + i));
      for (int k = 0; k < 10; k++) begin
         req = (k < 8) ? 4'b1111 : 4'b0000;
         @(negedge clk);
         chk($sformatf("t2_gnt%0d", k), 32'(gnt), (k < 8) ? 32'(exp_gnt(k)) : 32'h0);
         if (k >= 2) begin
            chk($sformatf("t2_rvalid%0d", k), 32'(rvalid), 32'(exp_gnt(k - 2)));
            chk($sformatf("t2_rdata%0d", k), 32'(rdata), 32'(rom_f(12'(12'h200 + exp_idx(k - 2)))));
         end
         tick();
      end

      // locked 64-pixel row on requester 2 while requester 0 waits
      set_addr(0, 12'h041);
      req      = 4'b0100;
      req_lock = 4'b0100;
      for (int k = 0; k < 64; k++) begin
         set_addr(2, 12'(12'h080 + k));
         if (k == 1) req = 4'b0101;
         @(negedge clk);
         chk($sformatf("t3_gnt%0d", k), 32'(gnt), 32'h4);
         chk($sformatf("t3_addr%0d", k), 32'(rom_addr), 32'(12'h080 + k));
         if (k >= 2) begin
            chk($sformatf("t3_rvalid%0d", k), 32'(rvalid), 32'h4);
            chk($sformatf("t3_rdata%0d", k), 32'(rdata), 32'(rom_f(12'(12'h080 + k - 2))));
         end
         tick();
      end
      req_lock = '0;
      @(negedge clk);
      chk("t3_release_gnt", 32'(gnt), 32'h1);
      chk("t3_rvalid_be", 32'(rvalid), 32'h4);
      chk("t3_rdata_be", 32'(rdata), 32'(rom_f(12'h0BE)));
      tick();
      req = '0;
      @(negedge clk);
      chk("t3_rvalid_bf", 32'(rvalid), 32'h4);
      chk("t3_rdata_bf", 32'(rdata), 32'(rom_f(12'h0BF)));
      tick();
      @(negedge clk);
      chk("t3_rvalid_r0", 32'(rvalid), 32'h1);
      chk("t3_rdata_r0", 32'(rdata), 32'hA1D);
      tick();

      // reset pulsed one clk after a grant, with reads in flight
      req = 4'b0001;
      @(negedge clk);
      chk("t4_gnt_a", 32'(gnt), 32'h1);
      tick();
      @(negedge clk);
      chk("t4_gnt_b", 32'(gnt), 32'h1);
      tick();
      @(negedge clk);
      chk("t4_rvalid_pre", 32'(rvalid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t4_gnt_rst", 32'(gnt), 32'h0);
      chk("t4_rvalid_rst", 32'(rvalid), 32'h0);
      chk("t4_rdata_rst", 32'(rdata), 32'h0);
      chk("t4_rom_addr_rst", 32'(rom_addr), 32'h0);
      tick();
      rst_n = 1'b1;
      req   = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t4_rvalid_post%0d", k), 32'(rvalid), 32'h0);
         tick();
      end

      // requester 1 withdraws while requester 3 holds a locked grant
      req      = 4'b1000;
      req_lock = 4'b1000;
      @(negedge clk);
      chk("t5_gnt_own", 32'(gnt), 32'h8);
      tick();
      req = 4'b1010;
      @(negedge clk);
      chk("t5_gnt_hold", 32'(gnt), 32'h8);
      tick();
      req = 4'b1000;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("t5_gnt%0d", k), 32'(gnt), 32'h8);
         chk($sformatf("t5_rvalid%0d", k), 32'(rvalid), 32'h8);
         tick();
      end
      req      = '0;
      req_lock = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
